vga_scanout: RTL and testbench

- Downstream stage of the pixel processing unit: takes its 8-bit pixel bytes over the stb/ack handshake into a small FIFO.
- Generates 640x480@60 VGA timing, and on every active pixel drives 2-2-2 RGB from byte bits [7:2].
- Emits a one-cycle `sync` pulse at frame end so the upstream unit can restart its counters.
- Runs on the 25 MHz pixel clock, one pixel per clk.

---
 rtl/vga_timing_pkg.sv | 48 ++++
 rtl/pixel_fifo.sv | 66 ++++++
 rtl/vga_scanout.sv | 131 +++++++++++++
 tb/tb_vga_scanout.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, counter widths and pixel-byte field layout
// for the scanout stage and its pixel FIFO.
package vga_timing_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int SCALE      = 20;
    localparam int FIFO_DEPTH = 16;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;

    localparam int H_CNT_W = $clog2(H_TOTAL);
    localparam int V_CNT_W = $clog2(V_TOTAL);
    localparam int SCALE_W = $clog2(SCALE);
    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

    // Pixel byte layout; bits [1:0] carry no colour.
    localparam int R_HI = 7;
    localparam int R_LO = 6;
    localparam int G_HI = 5;
    localparam int G_LO = 4;
    localparam int B_HI = 3;
    localparam int B_LO = 2;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    function automatic rgb_t pixel_fields(input logic [7:0] pix);
        rgb_t c;
        c.r = pix[R_HI:R_LO];
        c.g = pix[G_HI:G_LO];
        c.b = pix[B_HI:B_LO];
        return c;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead byte FIFO between the upstream pixel handshake and the scanout fetch.
// Writes into a full FIFO and reads from an empty one are ignored.
module pixel_fifo
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_wr_s;
    logic          do_rd_s;

    // Status and qualified enables.
    always_comb begin
        full    = (count_r == (AW+1)'(DEPTH));
        empty   = (count_r == (AW+1)'(0));
        count   = count_r;
        rd_data = mem_r[rd_ptr_r];
        do_wr_s = wr_en && !full;
        do_rd_s = rd_en && !empty;
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: buffers upstream pixel bytes, generates 640x480@60 timing and drives
// registered 2-2-2 RGB, syncs and a frame-end pulse, each byte widened SCALE clocks.
module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int V_ACT   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_PULSE = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       stb_i,
    output logic       ack_i,
    output logic [1:0] red,
    output logic [1:0] green,
    output logic [1:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       sync,
    output logic       underflow
);

    localparam int V_TOT = V_ACT + V_FRONT + V_PULSE + V_BACK;
    localparam int VW    = $clog2(V_TOT);
    localparam int V_SS  = V_ACT + V_FRONT;
    localparam int V_SE  = V_SS + V_PULSE;
    localparam int H_SE  = H_SYNC_START + H_SYNC;

    logic [H_CNT_W-1:0] h_cnt_r;
    logic [VW-1:0]      v_cnt_r;
    logic [SCALE_W-1:0] scale_cnt_r;
    logic [7:0]         pixel_r;

    logic               active_s;
    logic               fetch_s;
    logic               has_data_s;
    logic               push_s;
    logic               pop_s;
    logic               frame_end_s;
    logic               h_blank_sync_s;
    logic               v_blank_sync_s;
    logic [7:0]         head_s;
    logic [7:0]         pix_s;
    logic               full_s;
    logic               empty_s;
    logic [FIFO_CW-1:0] count_s;
    rgb_t               rgb_s;

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (data_i),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // Decode the current counter position; pix_s is the byte shown at this position.
    always_comb begin
        active_s       = (h_cnt_r < H_CNT_W'(H_ACTIVE)) && (v_cnt_r < VW'(V_ACT));
        fetch_s        = active_s && (scale_cnt_r == SCALE_W'(0));
        has_data_s     = (count_s != FIFO_CW'(0));
        pop_s          = fetch_s && has_data_s;
        // ack_i in the term blocks a second push while upstream is still dropping stb_i.
        push_s         = stb_i && !ack_i && !full_s;
        frame_end_s    = (h_cnt_r == H_CNT_W'(0)) && (v_cnt_r == VW'(V_ACT));
        h_blank_sync_s = (h_cnt_r >= H_CNT_W'(H_SYNC_START)) && (h_cnt_r < H_CNT_W'(H_SE));
        v_blank_sync_s = (v_cnt_r >= VW'(V_SS)) && (v_cnt_r < VW'(V_SE));
        if (fetch_s) begin
            pix_s = has_data_s ? head_s : 8'h00;
        end else begin
            pix_s = pixel_r;
        end
        rgb_s = pixel_fields(pix_s);
    end

    // Raster counters, pixel fetch and registered pin drivers (one clk behind counters).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_r     <= H_CNT_W'(0);
            v_cnt_r     <= VW'(0);
            scale_cnt_r <= SCALE_W'(0);
            pixel_r     <= 8'h00;
            ack_i       <= 1'b0;
            red         <= 2'b00;
            green       <= 2'b00;
            blue        <= 2'b00;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            sync        <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (h_cnt_r == H_CNT_W'(H_TOTAL - 1)) begin
                h_cnt_r <= H_CNT_W'(0);
                v_cnt_r <= (v_cnt_r == VW'(V_TOT - 1)) ? VW'(0) : v_cnt_r + VW'(1);
            end else begin
                h_cnt_r <= h_cnt_r + H_CNT_W'(1);
            end

            if (!active_s || (scale_cnt_r == SCALE_W'(SCALE - 1))) begin
                scale_cnt_r <= SCALE_W'(0);
            end else begin
                scale_cnt_r <= scale_cnt_r + SCALE_W'(1);
            end

            if (fetch_s) begin
                pixel_r <= pix_s;
            end

            ack_i <= push_s;
            red   <= active_s ? rgb_s.r : 2'b00;
            green <= active_s ? rgb_s.g : 2'b00;
            blue  <= active_s ? rgb_s.b : 2'b00;
            hsync <= !h_blank_sync_s;
            vsync <= !v_blank_sync_s;
            sync  <= frame_end_s;

            if (frame_end_s) begin
                underflow <= 1'b0;
            end else if (fetch_s && empty_s) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout; vertical timing is shortened to 4+2+2+2 lines so a
// frame is 8000 clks, horizontal timing and FIFO use the real values.
`timescale 1ns/1ps
module tb_vga_scanout;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       stb_i = 1'b0;
    logic       ack_i;
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;
    logic       hsync;
    logic       vsync;
    logic       sync;
    logic       underflow;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;

    // Upstream model state.
    logic       src_en = 1'b0;
    logic       src_const = 1'b0;
    logic [7:0] next_val = 8'h00;
    logic       ack_seen = 1'b0;
    int         ack_cnt = 0;

    vga_scanout #(
        .V_ACT   (4),
        .V_FRONT (2),
        .V_PULSE (2),
        .V_BACK  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .stb_i     (stb_i),
        .ack_i     (ack_i),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hsync     (hsync),
        .vsync     (vsync),
        .sync      (sync),
        .underflow (underflow)
    );

    always #20 clk = ~clk;

    // Edges since reset release: pixel p is on the pins once edges == p+1.
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    // Upstream: present a byte, hold stb_i until ack_i is seen, drop it one clk later.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                stb_i    = 1'b0;
                ack_seen = 1'b0;
            end else if (stb_i) begin
                if (ack_seen) begin
                    stb_i    = 1'b0;
                    ack_seen = 1'b0;
                end else if (ack_i) begin
                    ack_seen = 1'b1;
                    ack_cnt  = ack_cnt + 1;
                    next_val = next_val + 8'd1;
                end
            end else if (src_en) begin
                data_i = src_const ? 8'hE4 : next_val;
                stb_i  = 1'b1;
            end
        end
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rgb(input string tag, input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
        n_cmp++;
        assert ({red, green, blue} === {r, g, b}) else begin
            n_bad++;
            $error("FAIL %s: observed rgb %0d/%0d/%0d expected %0d/%0d/%0d", tag, red, green, blue, r, g, b);
        end
    endtask

    task automatic goto_pix(input int p);
        int guard = 0;
        while (edges < p + 1 && guard < 50000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_cmp++;
        assert (edges == p + 1) else begin
            n_bad++;
            $error("FAIL goto_pix: observed edges %0d expected %0d", edges, p + 1);
        end
    endtask

    initial begin
        // Power-on reset held three clocks.
        #5 rst = 1'b0;
        #1;
        chk_bit("rst_ack", ack_i, 1'b0);
        chk_rgb("rst_rgb", 2'd0, 2'd0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_hsync", hsync, 1'b1);
        chk_bit("rst_vsync", vsync, 1'b1);
        chk_bit("rst_sync", sync, 1'b0);
        chk_bit("rst_uf", underflow, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Frame 0, no input: timing and starvation.
        goto_pix(0);
        chk_rgb("starve_black", 2'd0, 2'd0, 2'd0);
        chk_bit("starve_uf", underflow, 1'b1);
        chk_bit("h0_hsync", hsync, 1'b1);
        goto_pix(655);  chk_bit("hs_655", hsync, 1'b1);
        goto_pix(656);  chk_bit("hs_656", hsync, 1'b0);
        goto_pix(751);  chk_bit("hs_751", hsync, 1'b0);
        goto_pix(752);  chk_bit("hs_752", hsync, 1'b1);
        goto_pix(1455); chk_bit("hs_l1_655", hsync, 1'b1);
        goto_pix(1456); chk_bit("hs_l1_656", hsync, 1'b0);
        goto_pix(3199);
        chk_bit("sync_pre", sync, 1'b0);
        chk_bit("uf_pre_sync", underflow, 1'b1);
        goto_pix(3200);
        chk_bit("sync_f0", sync, 1'b1);
        chk_bit("uf_clr", underflow, 1'b0);
        goto_pix(3201);
        chk_bit("sync_post", sync, 1'b0);

        // Fill the FIFO during vertical blanking with 0x00, 0x01, ...
        goto_pix(3300);
        src_en = 1'b1;
        goto_pix(3400);
        chk_int("fill_acks", ack_cnt, 16);
        chk_bit("fill_stb_held", stb_i, 1'b1);
        chk_bit("fill_ack_low", ack_i, 1'b0);
        goto_pix(4799); chk_bit("vs_l5", vsync, 1'b1);
        goto_pix(4800); chk_bit("vs_l6", vsync, 1'b0);
        goto_pix(6399); chk_bit("vs_l7", vsync, 1'b0);
        goto_pix(6400); chk_bit("vs_l8", vsync, 1'b1);
        goto_pix(7999);
        chk_int("full_acks", ack_cnt, 16);
        chk_bit("full_ack_low", ack_i, 1'b0);

        // Frame 1 line 0: bytes k shown at h = 20k .. 20k+19.
        goto_pix(8000);
        chk_bit("pop_full_noack", ack_i, 1'b0);
        chk_rgb("byte0", 2'd0, 2'd0, 2'd0);
        goto_pix(8001);
        chk_bit("ack_after_pop", ack_i, 1'b1);
        goto_pix(8079); chk_rgb("byte3_end", 2'd0, 2'd0, 2'd0);
        goto_pix(8080); chk_rgb("byte4", 2'd0, 2'd0, 2'd1);
        goto_pix(8099); chk_rgb("byte4_end", 2'd0, 2'd0, 2'd1);
        goto_pix(8300); chk_rgb("byte15", 2'd0, 2'd0, 2'd3);
        goto_pix(8320); chk_rgb("byte16", 2'd0, 2'd1, 2'd0);
        goto_pix(8639); chk_rgb("byte31", 2'd0, 2'd1, 2'd3);
        goto_pix(8640); chk_rgb("hblank_black", 2'd0, 2'd0, 2'd0);
        goto_pix(8800);
        chk_rgb("byte32", 2'd0, 2'd2, 2'd0);
        chk_bit("fed_no_uf", underflow, 1'b0);
        src_const = 1'b1;

        // Constant 0xE4 stream.
        goto_pix(10400); chk_rgb("e4_h0", 2'd3, 2'd2, 2'd1);
        goto_pix(10419); chk_rgb("e4_h19", 2'd3, 2'd2, 2'd1);
        goto_pix(11039); chk_rgb("e4_h639", 2'd3, 2'd2, 2'd1);
        goto_pix(11040); chk_rgb("e4_h640", 2'd0, 2'd0, 2'd0);
        goto_pix(11199); chk_bit("sync1_pre", sync, 1'b0);
        goto_pix(11200);
        chk_bit("sync_f1", sync, 1'b1);
        chk_bit("uf_f1", underflow, 1'b0);
        goto_pix(11201); chk_bit("sync1_post", sync, 1'b0);
        goto_pix(16100); chk_rgb("e4_f2", 2'd3, 2'd2, 2'd1);

        // Mid-frame reset with a full FIFO.
        src_en = 1'b0;
        rst = 1'b0;
        #1;
        chk_rgb("mid_rst_rgb", 2'd0, 2'd0, 2'd0);
        chk_bit("mid_rst_ack", ack_i, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_bit("mid_rst_stb", stb_i, 1'b0);
        chk_bit("mid_rst_sync", sync, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        goto_pix(0);
        chk_rgb("flushed_black", 2'd0, 2'd0, 2'd0);
        chk_bit("flushed_uf", underflow, 1'b1);
        goto_pix(700);
        chk_bit("pre_rst_hsync", hsync, 1'b0);
        rst = 1'b0;
        #1;
        chk_bit("rst_hsync_rel", hsync, 1'b1);
        chk_bit("rst_uf_clr", underflow, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
